// File: rtl/avalon_st_pkt_fifo.sv
// rtl/avalon_st_pkt_fifo.sv - Avalon-ST packet FIFO with framing check; AVST_PKT_FIFO_STORE_FWD_EN selects store-and-forward
module avalon_st_pkt_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH = 16,
    localparam int EMPTY_WIDTH = (DATA_WIDTH / 8 > 1) ? $clog2(DATA_WIDTH / 8) : 1,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sink_vld,
    input  logic                   sink_sop,
    input  logic                   sink_eop,
    input  logic [DATA_WIDTH-1:0]  sink_data,
    input  logic [EMPTY_WIDTH-1:0] sink_empty,
    output logic                   sink_rdy,
    output logic                   src_vld,
    output logic                   src_sop,
    output logic                   src_eop,
    output logic [DATA_WIDTH-1:0]  src_data,
    output logic [EMPTY_WIDTH-1:0] src_empty,
    input  logic                   src_rdy,
    output logic [CW-1:0]          fill_level,
    output logic [CW-1:0]          pkt_count,
    output logic                   frame_err
);

    localparam int ENTRY_W = DATA_WIDTH + EMPTY_WIDTH + 2;

    typedef enum logic {
        ST_IDLE,
        ST_IN_PKT
    } trk_state_t;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               wr_en;
    logic               rd_en;
    logic               frame_viol;
    trk_state_t         trk_q;
    trk_state_t         trk_d;

    assign sink_rdy = (fill_level != CW'(DEPTH));
    assign wr_en    = sink_vld && sink_rdy;
    assign rd_en    = src_vld && src_rdy;

    // Source fields come straight from the head entry, so there is no sink-to-source path.
    assign {src_data, src_empty, src_sop, src_eop} = mem[rd_ptr];

`ifdef AVST_PKT_FIFO_STORE_FWD_EN
    logic rel_q;

    // rel_q keeps a packet flowing once its first beat has left, until its eop is read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rel_q <= 1'b0;
        end else if (rd_en) begin
            rel_q <= !src_eop;
        end
    end

    assign src_vld = (fill_level != '0) &&
                     ((pkt_count != '0) || (fill_level == CW'(DEPTH)) || rel_q);
`else
    assign src_vld = (fill_level != '0);
`endif

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {sink_data, sink_empty, sink_sop, sink_eop};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
            pkt_count  <= '0;
            frame_err  <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   fill_level <= fill_level + 1'b1;
                2'b01:   fill_level <= fill_level - 1'b1;
                default: fill_level <= fill_level;
            endcase
            case ({wr_en && sink_eop, rd_en && src_eop})
                2'b10:   pkt_count <= pkt_count + 1'b1;
                2'b01:   pkt_count <= pkt_count - 1'b1;
                default: pkt_count <= pkt_count;
            endcase
            if (frame_viol) begin
                frame_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            trk_q <= ST_IDLE;
        end else begin
            trk_q <= trk_d;
        end
    end

    // Offending beats are still stored; only the sticky flag records the violation.
    always_comb begin
        trk_d      = trk_q;
        frame_viol = 1'b0;
        if (wr_en) begin
            case (trk_q)
                ST_IDLE: begin
                    if (!sink_sop) begin
                        frame_viol = 1'b1;
                    end else if (!sink_eop) begin
                        trk_d = ST_IN_PKT;
                    end
                end
                ST_IN_PKT: begin
                    if (sink_sop) begin
                        frame_viol = 1'b1;
                    end
                    if (sink_eop) begin
                        trk_d = ST_IDLE;
                    end
                end
                default: trk_d = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_avalon_st_pkt_fifo.sv
// tb/tb_avalon_st_pkt_fifo.sv - scoreboard bench for avalon_st_pkt_fifo
module tb_avalon_st_pkt_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int EW    = 2;
    localparam int CW    = 5;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [EW-1:0] empty;
        logic          sop;
        logic          eop;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sink_vld = 1'b0;
    logic          sink_sop = 1'b0;
    logic          sink_eop = 1'b0;
    logic [DW-1:0] sink_data = '0;
    logic [EW-1:0] sink_empty = '0;
    logic          sink_rdy;
    logic          src_vld;
    logic          src_sop;
    logic          src_eop;
    logic [DW-1:0] src_data;
    logic [EW-1:0] src_empty;
    logic          src_rdy = 1'b0;
    logic [CW-1:0] fill_level;
    logic [CW-1:0] pkt_count;
    logic          frame_err;

    beat_t exp_q[$];
    beat_t wr_beat;
    logic  wr_fire = 1'b0;
    logic  rd_fire = 1'b0;
    logic  rd_eop = 1'b0;
    int    model_fill = 0;
    int    model_pkts = 0;
    logic  model_ferr = 1'b0;
    logic  model_in_pkt = 1'b0;
    logic  model_rel = 1'b0;
    int    errors = 0;
    int    checks = 0;
    int    src_mode = 0;

    avalon_st_pkt_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .sink_vld   (sink_vld),
        .sink_sop   (sink_sop),
        .sink_eop   (sink_eop),
        .sink_data  (sink_data),
        .sink_empty (sink_empty),
        .sink_rdy   (sink_rdy),
        .src_vld    (src_vld),
        .src_sop    (src_sop),
        .src_eop    (src_eop),
        .src_data   (src_data),
        .src_empty  (src_empty),
        .src_rdy    (src_rdy),
        .fill_level (fill_level),
        .pkt_count  (pkt_count),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (src_mode)
                0:       src_rdy = 1'b0;
                1:       src_rdy = 1'b1;
                default: src_rdy = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: every beat the DUT hands over is popped from the scoreboard and compared.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            rd_fire = 1'b0;
            if (!rst && src_vld && src_rdy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("src_data", 64'(src_data), 64'(e.data));
                    check("src_sop", 64'(src_sop), 64'(e.sop));
                    check("src_eop", 64'(src_eop), 64'(e.eop));
                    if (e.eop) begin
                        check("src_empty", 64'(src_empty), 64'(e.empty));
                    end
                    rd_fire = 1'b1;
                    rd_eop  = e.eop;
                end
            end
        end
    end

    // Reference model: occupancy, packet and framing rules applied per transfer.
    always begin
        logic exp_vld;
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            model_fill   = 0;
            model_pkts   = 0;
            model_ferr   = 1'b0;
            model_in_pkt = 1'b0;
            model_rel    = 1'b0;
        end else begin
            if (wr_fire) begin
                exp_q.push_back(wr_beat);
                model_fill++;
                if (wr_beat.eop) model_pkts++;
                if ((!model_in_pkt && !wr_beat.sop) || (model_in_pkt && wr_beat.sop)) model_ferr = 1'b1;
                model_in_pkt = wr_beat.eop ? 1'b0 : (wr_beat.sop ? 1'b1 : model_in_pkt);
            end
            if (rd_fire) begin
                model_fill--;
                if (rd_eop) model_pkts--;
                model_rel = !rd_eop;
            end
        end
`ifdef AVST_PKT_FIFO_STORE_FWD_EN
        exp_vld = (model_fill != 0) && ((model_pkts != 0) || (model_fill == DEPTH) || model_rel);
`else
        exp_vld = (model_fill != 0);
`endif
        #3;
        check("fill_level", 64'(fill_level), 64'(model_fill));
        check("pkt_count", 64'(pkt_count), 64'(model_pkts));
        check("frame_err", 64'(frame_err), 64'(model_ferr));
        check("src_vld", 64'(src_vld), 64'(exp_vld));
        check("sink_rdy", 64'(sink_rdy), 64'(model_fill != DEPTH));
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_beat(input beat_t b);
        int   w;
        logic acc;
        w = 0;
        sink_vld   = 1'b1;
        sink_data  = b.data;
        sink_empty = b.empty;
        sink_sop   = b.sop;
        sink_eop   = b.eop;
        do begin
            @(negedge clk);
            acc = sink_rdy;
            if (acc) begin
                wr_beat = b;
                wr_fire = 1'b1;
            end
            @(posedge clk);
            #1;
            wr_fire = 1'b0;
            w++;
        end while (!acc && w < 2000);
        if (!acc) check("sink_accept_timeout", 64'(0), 64'(1));
        sink_vld = 1'b0;
    endtask

    task automatic send_pkt(input int len, input int gap);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            if (i == len - 1 && gap > 0) idle(gap);
            b.data  = $urandom;
            b.sop   = (i == 0);
            b.eop   = (i == len - 1);
            b.empty = b.eop ? EW'($urandom) : '0;
            send_beat(b);
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        src_mode = 1;
        while (model_fill != 0 && w < 2000) begin
            idle(1);
            w++;
        end
        if (model_fill != 0) check("drain_timeout", 64'(model_fill), 64'(0));
        idle(2);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
    endtask

    initial begin
        beat_t b;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_src_vld", 64'(src_vld), 64'(0));
        check("rst_fill", 64'(fill_level), 64'(0));
        check("rst_pkt", 64'(pkt_count), 64'(0));
        check("rst_frame_err", 64'(frame_err), 64'(0));
        check("rst_sink_rdy", 64'(sink_rdy), 64'(1));
        @(posedge clk);
        #1;

        // Single-beat packet appears on the source the cycle after it is written.
        src_mode = 1;
        idle(1);
        b = '{data: 32'hA5A5A5A5, empty: 2'd2, sop: 1'b1, eop: 1'b1};
        send_beat(b);
        @(negedge clk);
        check("single_vld", 64'(src_vld), 64'(1));
        check("single_data", 64'(src_data), 64'(32'hA5A5A5A5));
        check("single_empty", 64'(src_empty), 64'(2));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("single_fill_after", 64'(fill_level), 64'(0));
        @(posedge clk);
        #1;

        // Fill to DEPTH with the source stalled, then release one beat.
        src_mode = 0;
        idle(1);
        send_pkt(16, 0);
        @(negedge clk);
        check("full_fill", 64'(fill_level), 64'(16));
        check("full_sink_rdy", 64'(sink_rdy), 64'(0));
        src_mode = 1;
        @(negedge clk);
        src_mode = 0;
        @(negedge clk);
        check("after_read_fill", 64'(fill_level), 64'(15));
        check("after_read_sink_rdy", 64'(sink_rdy), 64'(1));
        @(posedge clk);
        #1;
        drain();

        // Preload, then stream 40 beats at full rate through the pointer wrap.
        src_mode = 0;
        idle(1);
        send_pkt(5, 0);
        src_mode = 1;
        send_pkt(40, 0);
        drain();

        // Short packet with a gap before eop, then one longer than DEPTH.
        send_pkt(3, 2);
        drain();
        send_pkt(20, 0);
        drain();

        // Randomized traffic with random backpressure.
        src_mode = 2;
        for (int p = 0; p < 40; p++) begin
            send_pkt($urandom_range(1, 8), $urandom_range(0, 2));
            idle($urandom_range(0, 2));
        end
        drain();

        // Framing violation, then reset in the middle of a packet.
        src_mode = 0;
        pulse_rst();
        b = '{data: 32'h12345678, empty: 2'd0, sop: 1'b0, eop: 1'b0};
        send_beat(b);
        @(negedge clk);
        check("viol_frame_err", 64'(frame_err), 64'(1));
        @(posedge clk);
        #1;
        b = '{data: 32'hCAFEF00D, empty: 2'd0, sop: 1'b1, eop: 1'b0};
        send_beat(b);
        pulse_rst();
        @(negedge clk);
        check("post_rst_frame_err", 64'(frame_err), 64'(0));
        check("post_rst_fill", 64'(fill_level), 64'(0));
        check("post_rst_src_vld", 64'(src_vld), 64'(0));
        @(posedge clk);
        #1;
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/avalon_st_pkt_fifo.md
AVALON_ST_PKT_FIFO -- requirements
Module: avalon_st_pkt_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, sink/source data width in bits, multiple of 8, minimum 8.
REQ-002 SHALL have parameter DEPTH, default 16, storage entries, power of two, minimum 4.
REQ-003 SHALL define EMPTY_WIDTH = max(1, $clog2(DATA_WIDTH/8)); each entry holds data, empty, sop and eop.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 sink_vld, sink_sop, sink_eop  in  1 each  sink beat qualifiers.
REQ-007 sink_data  in  DATA_WIDTH; sink_empty  in  EMPTY_WIDTH (unused bytes on eop beat).
REQ-008 sink_rdy  out  1  FIFO can accept a beat this cycle.
REQ-009 src_vld, src_sop, src_eop  out  1 each; src_data  out  DATA_WIDTH; src_empty  out  EMPTY_WIDTH.
REQ-010 src_rdy  in  1  downstream accepts beat.
REQ-011 fill_level  out  $clog2(DEPTH)+1  stored beats.
REQ-012 pkt_count  out  $clog2(DEPTH)+1  complete packets (eop written, not yet read).
REQ-013 frame_err  out  1  sticky framing-violation flag.

Function
REQ-014 Transfer occurs on a cycle with vld and rdy both high; sink_rdy = (fill_level != DEPTH), independent of src_rdy.
REQ-015 Beat written at cycle N SHALL be presentable on src_* at cycle N+1 earliest (one-cycle latency, no combinational sink-to-source path).
REQ-016 src_* SHALL be driven directly from storage at read pointer; src_vld low when fill_level == 0; src_data/empty/sop/eop hold while src_vld high and src_rdy low.
REQ-017 Simultaneous write and read SHALL leave fill_level unchanged; write-only +1, read-only -1.
REQ-018 Pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-019 pkt_count SHALL increment on accepted sink beat with sink_eop, decrement on accepted src beat with src_eop; both same cycle -> unchanged.
REQ-020 Framing tracker SHALL have states IDLE (outside packet) and IN_PKT; accepted sop moves to IN_PKT, accepted eop moves to IDLE, sop+eop single-beat stays IDLE.
REQ-021 Accepted beat without sop in IDLE, or with sop in IN_PKT, SHALL set frame_err; beat still stored unchanged.
REQ-022 frame_err SHALL remain set until rst.
REQ-023 sink_empty SHALL be stored as-is; src_empty meaningful only when src_eop high.

Reset
REQ-024 On rst high at a clock edge: pointers, fill_level, pkt_count = 0; frame_err = 0; tracker = IDLE; src_vld = 0; sink_rdy = 1 from first cycle after rst deasserts.
REQ-025 rst during a packet SHALL discard all stored beats including partial packets; storage contents need not be cleared.

Configuration
REQ-026 Macro AVST_PKT_FIFO_STORE_FWD_EN selects store-and-forward mode.
REQ-027 Defined: src_vld SHALL be high only when fill_level != 0 and (pkt_count != 0 or fill_level == DEPTH); full-with-no-eop releases beats (cut-through) to avoid deadlock on packets longer than DEPTH.
REQ-028 Defined: once first beat of a packet is released, remaining beats of that packet SHALL be released as available until its eop is read.
REQ-029 Undefined: src_vld = (fill_level != 0) (cut-through); pkt_count still maintained.

Verification
REQ-030 Single beat sop=1 eop=1 data=0xA5A5A5A5 empty=2, src_rdy=1 -> src_vld high next cycle with same fields; fill_level back to 0 after read.
REQ-031 Write 16 beats with src_rdy=0, DEPTH=16 -> sink_rdy low after 16th acceptance, fill_level=16; one read -> sink_rdy high next cycle.
REQ-032 Continuous write+read at full rate over 40 beats -> fill_level constant, data order preserved across pointer wrap.
REQ-033 STORE_FWD_EN, 3-beat packet with 2-cycle gap before eop -> src_vld stays low until cycle after eop accepted, then 3 beats back-to-back.
REQ-034 STORE_FWD_EN, DEPTH=16, 20-beat packet -> at fill 16 src_vld rises, all 20 beats drain in order, no deadlock.
REQ-035 Beat with sop=0 after reset, then rst mid-packet -> frame_err=1 next cycle; after rst frame_err=0, fill_level=0, src_vld=0.
